scmp_bus_ctrl: RTL and testbench



---
 rtl/scmp_bus_pkg.sv | 28 ++
 rtl/scmp_bus_rdmux.sv | 21 ++
 rtl/scmp_bus_ctrl.sv | 156 +++++++++++++++
 tb/tb_scmp_bus_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scmp_bus_pkg.sv
// Shared types and helpers for the SC/MP external-bus controller.
package scmp_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    XFER,
    CAPT,
    DONE
  } bus_state_t;

  // Bit positions of the status flags inside the latched flags nibble ({H,D,I,R}).
  localparam int FLAG_R = 0;
  localparam int FLAG_I = 1;
  localparam int FLAG_D = 2;
  localparam int FLAG_H = 3;

  // Widest wait-state table the helper accepts (RSEL_W up to 4).
  localparam int MAX_REG = 16;

  // Pick the 4-bit wait-state count of one region out of a packed table.
  function automatic logic [3:0] wait_of(input logic [4*MAX_REG-1:0] waits,
                                         input logic [3:0]           region);
    return waits[4*region +: 4];
  endfunction

endpackage

// File: rtl/scmp_bus_rdmux.sv
// N_REG-way byte-slice multiplexer selecting one region's read data.
module scmp_bus_rdmux #(
  parameter int RSEL_W = 1
) (
  input  logic [8*(2**RSEL_W)-1:0] rdata_i,
  input  logic [RSEL_W-1:0]        sel_i,
  output logic [7:0]               data_o
);

  localparam int N_REG = 2**RSEL_W;

  logic [7:0] slice [N_REG];

  // Split the packed bus into per-region bytes, region 0 in the LSBs.
  for (genvar gi = 0; gi < N_REG; gi++) begin : g_slice
    assign slice[gi] = rdata_i[8*gi +: 8];
  end

  assign data_o = slice[sel_i];

endmodule

// File: rtl/scmp_bus_ctrl.sv
// SC/MP external-bus controller: bank/flag latch at ADS, region decode,
// per-region wait states via hold_n, registered read data, sticky error.
module scmp_bus_ctrl
  import scmp_bus_pkg::*;
#(
  parameter int                        ADDR_W   = 12,
  parameter int                        BANK_W   = 4,
  parameter int                        RSEL_W   = 1,
  parameter logic [4*(2**RSEL_W)-1:0]  WAIT_CYC = '0,
  parameter logic [(2**RSEL_W)-1:0]    RO_MASK  = {{((2**RSEL_W)-1){1'b0}}, 1'b1}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ads_n,
  input  logic                       rd_n,
  input  logic                       wr_n,
  input  logic [ADDR_W-1:0]          cpu_addr,
  input  logic [7:0]                 cpu_do,
  output logic [7:0]                 cpu_di,
  output logic                       hold_n,
  output logic [BANK_W+ADDR_W-1:0]   mem_addr,
  output logic [7:0]                 mem_wdata,
  output logic [(2**RSEL_W)-1:0]     mem_re,
  output logic [(2**RSEL_W)-1:0]     mem_we,
  input  logic [8*(2**RSEL_W)-1:0]   mem_rdata,
  output logic [3:0]                 flags,
  output logic                       err,
  input  logic                       err_clr
);

  localparam int                  N_REG    = 2**RSEL_W;
  localparam logic [N_REG-1:0]    ONE      = N_REG'(1);
  localparam logic [4*MAX_REG-1:0] WAIT_EXT = (4*MAX_REG)'(WAIT_CYC);

  bus_state_t          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [BANK_W-1:0]   bank_q, bank_d;
  logic [3:0]          flags_q, flags_d;
  logic                is_wr_q, is_wr_d;
  logic [7:0]          cpu_di_q, cpu_di_d;
  logic                err_q, err_d;
  logic                err_set;
  logic [N_REG-1:0]    re_c, we_c;

  logic [RSEL_W-1:0]   region;
  logic [3:0]          wait_sel;
  logic [7:0]          rd_slice;

  assign region   = bank_q[RSEL_W-1:0];
  assign wait_sel = wait_of(WAIT_EXT, 4'(region));

  scmp_bus_rdmux #(
    .RSEL_W (RSEL_W)
  ) u_rdmux (
    .rdata_i (mem_rdata),
    .sel_i   (region),
    .data_o  (rd_slice)
  );

  // Next-state, strobe pulses and error detection; ADS outside IDLE aborts.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bank_d   = bank_q;
    flags_d  = flags_q;
    is_wr_d  = is_wr_q;
    cpu_di_d = cpu_di_q;
    err_set  = 1'b0;
    re_c     = '0;
    we_c     = '0;

    if (!ads_n) begin
      bank_d  = cpu_do[BANK_W-1:0];
      flags_d = cpu_do[7:4];
      state_d = ADDR;
      if (state_q != IDLE) begin
        err_set  = 1'b1;
        cpu_di_d = 8'hFF;
      end
    end else begin
      case (state_q)
        IDLE: ;
        ADDR: begin
          if (!rd_n || !wr_n) begin
            // A simultaneous read and write strobe is treated as a write.
            is_wr_d = !wr_n;
            cnt_d   = wait_sel;
            state_d = (wait_sel != 4'd0) ? WAIT : XFER;
            if (!rd_n && !wr_n) err_set = 1'b1;
          end
        end
        WAIT: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = XFER;
        end
        XFER: begin
          if (is_wr_q) begin
            if (RO_MASK[region]) err_set = 1'b1;
            else                 we_c    = ONE << region;
            state_d = DONE;
          end else begin
            re_c    = ONE << region;
            state_d = CAPT;
          end
        end
        CAPT: begin
          cpu_di_d = rd_slice;
          state_d  = DONE;
        end
        DONE: begin
          if (rd_n && wr_n) begin
            cpu_di_d = 8'hFF;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A new error wins over a clear arriving in the same cycle.
    if (err_set)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      bank_q   <= '0;
      flags_q  <= 4'd0;
      is_wr_q  <= 1'b0;
      cpu_di_q <= 8'hFF;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bank_q   <= bank_d;
      flags_q  <= flags_d;
      is_wr_q  <= is_wr_d;
      cpu_di_q <= cpu_di_d;
      err_q    <= err_d;
    end
  end

  assign hold_n    = !(state_q inside {WAIT, XFER, CAPT});
  assign mem_re    = re_c;
  assign mem_we    = we_c;
  assign mem_wdata = cpu_do;
  assign mem_addr  = {bank_q, cpu_addr};
  assign cpu_di    = cpu_di_q;
  assign flags     = flags_q;
  assign err       = err_q;

endmodule

// File: tb/tb_scmp_bus_ctrl.sv
// Self-checking bench for scmp_bus_ctrl with four regions.
module tb_scmp_bus_ctrl;

  localparam logic [15:0] WAITS = 16'h3F02;   // r0=2, r1=0, r2=15, r3=3
  localparam logic [3:0]  ROM   = 4'b0001;    // region 0 write-protected

  logic        clk = 1'b0;
  logic        rst, ads_n, rd_n, wr_n, err_clr;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_do, cpu_di, mem_wdata;
  logic        hold_n, err;
  logic [15:0] mem_addr;
  logic [3:0]  mem_re, mem_we, flags;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model of the board: wait counts, protection and read data per region.
  int         waits_m [4] = '{2, 0, 15, 3};
  bit         ro_m    [4] = '{1, 0, 0, 0};
  logic [7:0] rdata_m [4] = '{8'h11, 8'h5C, 8'hE2, 8'h3D};

  assign mem_rdata = {rdata_m[3], rdata_m[2], rdata_m[1], rdata_m[0]};

  always #5 clk = ~clk;

  scmp_bus_ctrl #(
    .ADDR_W   (12),
    .BANK_W   (4),
    .RSEL_W   (2),
    .WAIT_CYC (WAITS),
    .RO_MASK  (ROM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ads_n     (ads_n),
    .rd_n      (rd_n),
    .wr_n      (wr_n),
    .cpu_addr  (cpu_addr),
    .cpu_do    (cpu_do),
    .cpu_di    (cpu_di),
    .hold_n    (hold_n),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .flags     (flags),
    .err       (err),
    .err_clr   (err_clr)
  );

  typedef struct {
    logic [7:0]  ado;
    logic [11:0] addr;
    bit          rd;
    bit          wr;
    logic [7:0]  wd;
    int          hold;
    logic [3:0]  re;
    logic [3:0]  we;
    logic [7:0]  di;
    bit          err;
  } vec_t;

  typedef struct {
    int         hold_cnt;
    logic [3:0] re_or;
    int         re_cnt;
    logic [3:0] we_or;
    int         we_cnt;
    logic [7:0] wd_seen;
    logic [7:0] di_done;
    logic [7:0] di_after;
    logic       err_done;
    logic       err_after;
    bit         timeout;
  } meas_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected behaviour of one transaction, straight from the bus rules.
  function automatic vec_t model(input logic [7:0] ado, input logic [11:0] addr,
                                 input bit rd, input bit wr, input logic [7:0] wd);
    vec_t v;
    int   r;
    r      = int'(ado[1:0]);
    v.ado  = ado; v.addr = addr; v.rd = rd; v.wr = wr; v.wd = wd;
    v.hold = waits_m[r] + (wr ? 1 : 2);
    v.re   = wr ? 4'b0 : (4'b1 << r);
    v.we   = (wr && !ro_m[r]) ? (4'b1 << r) : 4'b0;
    v.di   = wr ? 8'hFF : rdata_m[r];
    v.err  = (rd && wr) || (wr && ro_m[r]);
    return v;
  endfunction

  // ADS cycle: bank/flags on cpu_do; returns at the following falling edge.
  task automatic ads_phase(input logic [7:0] ado, input logic [11:0] addr);
    ads_n    = 1'b0;
    cpu_do   = ado;
    cpu_addr = addr;
    @(negedge clk);
    ads_n    = 1'b1;
  endtask

  // Strobe phase: observe hold_n and pulses until hold_n is released, then end the cycle.
  task automatic data_phase(input bit rd, input bit wr, input logic [7:0] wd, output meas_t m);
    bit seen = 0;
    bit done = 0;
    m = '{default: '0};
    rd_n   = !rd;
    wr_n   = !wr;
    cpu_do = wd;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (mem_re != 4'b0) begin m.re_cnt++; m.re_or |= mem_re; end
      if (mem_we != 4'b0) begin m.we_cnt++; m.we_or |= mem_we; m.wd_seen = mem_wdata; end
      if (!hold_n) begin m.hold_cnt++; seen = 1; end
      else if (seen) done = 1;
    end
    m.timeout  = !done;
    m.di_done  = cpu_di;
    m.err_done = err;
    rd_n = 1'b1;
    wr_n = 1'b1;
    @(negedge clk);
    m.di_after  = cpu_di;
    m.err_after = err;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_cleared", err, 1'b0);
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    meas_t m;
    ads_phase(v.ado, v.addr);
    check("flags_latch", flags, v.ado[7:4]);
    check("mem_addr", mem_addr, {v.ado[3:0], v.addr});
    data_phase(v.rd, v.wr, v.wd, m);
    check("no_timeout", m.timeout, 1'b0);
    check("hold_cycles", m.hold_cnt, v.hold);
    check("mem_re", m.re_or, v.re);
    check("re_pulses", m.re_cnt, (v.re != 4'b0) ? 1 : 0);
    check("mem_we", m.we_or, v.we);
    check("we_pulses", m.we_cnt, (v.we != 4'b0) ? 1 : 0);
    if (v.we != 4'b0) check("mem_wdata", m.wd_seen, v.wd);
    check("cpu_di_done", m.di_done, v.di);
    check("cpu_di_idle", m.di_after, 8'hFF);
    check("err", m.err_done, v.err);
    $display("txn %0d ado=%h addr=%h rd=%0d wr=%0d hold=%0d re=%b we=%b di=%h err=%0d",
             idx, v.ado, v.addr, v.rd, v.wr, m.hold_cnt, m.re_or, m.we_or, m.di_done, m.err_done);
    clear_err();
  endtask

  vec_t vecs [7];

  initial begin
    meas_t m;
    int    stray;

    vecs[0] = '{8'hA1, 12'h123, 1, 0, 8'h00,  2, 4'b0010, 4'b0000, 8'h5C, 0}; // zero-wait read
    vecs[1] = '{8'h63, 12'h0F0, 0, 1, 8'h7E,  4, 4'b0000, 4'b1000, 8'hFF, 0}; // 3-wait write
    vecs[2] = '{8'h90, 12'h456, 0, 1, 8'h33,  3, 4'b0000, 4'b0000, 8'hFF, 1}; // protected write
    vecs[3] = '{8'h21, 12'h777, 1, 1, 8'hC4,  1, 4'b0000, 4'b0010, 8'hFF, 1}; // both strobes
    vecs[4] = '{8'hF2, 12'hFFF, 1, 0, 8'h00, 17, 4'b0100, 4'b0000, 8'hE2, 0}; // 15 wait states
    vecs[5] = '{8'h04, 12'h000, 1, 0, 8'h00,  4, 4'b0001, 4'b0000, 8'h11, 0}; // back-to-back
    vecs[6] = '{8'h57, 12'h9AB, 1, 0, 8'h00,  5, 4'b1000, 4'b0000, 8'h3D, 0}; // back-to-back

    rst = 1'b1; ads_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; err_clr = 1'b0;
    cpu_addr = 12'h0; cpu_do = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_hold_n", hold_n, 1'b1);
    check("rst_cpu_di", cpu_di, 8'hFF);
    check("rst_pulses", {mem_re, mem_we}, 8'h00);
    check("rst_flags", flags, 4'h0);
    check("rst_err", err, 1'b0);
    check("rst_bank", mem_addr[15:12], 4'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_txn(vecs[i], i);

    // Reset while stretched in WAIT: released on the next edge, no pulse afterwards.
    ads_phase(8'hF2, 12'hABC);
    rd_n = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_hold", hold_n, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_hold_n", hold_n, 1'b1);
    check("midrst_pulses", {mem_re, mem_we}, 8'h00);
    check("midrst_cpu_di", cpu_di, 8'hFF);
    check("midrst_flags", flags, 4'h0);
    check("midrst_addr", mem_addr, 16'h0ABC);
    rst = 1'b0;
    rd_n = 1'b1;
    stray = 0;
    repeat (20) begin
      @(negedge clk);
      if (!hold_n || mem_re != 4'b0 || mem_we != 4'b0) stray++;
    end
    check("post_rst_quiet", stray, 0);
    $display("txn reset-in-wait done");

    // ADS during WAIT: relatch, flag an error, drop the pending read, then a clean read.
    ads_phase(8'hF2, 12'h321);
    rd_n = 1'b0;
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (mem_re != 4'b0 || mem_we != 4'b0) stray++;
    end
    ads_n  = 1'b0;
    cpu_do = 8'h50;
    rd_n   = 1'b1;
    @(negedge clk);
    if (mem_re != 4'b0 || mem_we != 4'b0) stray++;
    ads_n = 1'b1;
    check("abort_err", err, 1'b1);
    check("abort_flags", flags, 4'h5);
    check("abort_addr", mem_addr, 16'h0321);
    check("abort_hold_n", hold_n, 1'b1);
    data_phase(1, 0, 8'h00, m);
    check("abort_no_pulse", stray, 0);
    check("after_abort_hold", m.hold_cnt, 4);
    check("after_abort_re", m.re_or, 4'b0001);
    check("after_abort_di", m.di_done, 8'h11);
    $display("txn ads-abort hold=%0d di=%h", m.hold_cnt, m.di_done);
    clear_err();

    // Clear held during a protected write: the new error wins, then clears.
    ads_phase(8'h80, 12'h010);
    err_clr = 1'b1;
    data_phase(0, 1, 8'h99, m);
    check("setwins_err", m.err_done, 1'b1);
    check("setwins_cleared", m.err_after, 1'b0);
    check("setwins_we", m.we_cnt, 0);
    err_clr = 1'b0;
    $display("txn set-vs-clear err=%0d then %0d", m.err_done, m.err_after);

    // Randomised transactions against the model.
    for (int i = 0; i < 30; i++) begin
      logic [7:0]  ado;
      logic [11:0] addr;
      bit          rd, wr;
      ado  = 8'($urandom);
      addr = 12'($urandom);
      if ($urandom_range(7) == 0) begin rd = 1; wr = 1; end
      else begin wr = 1'($urandom); rd = !wr; end
      run_txn(model(ado, addr, rd, wr, 8'($urandom)), 100 + i);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
